data_mem_ctrl: RTL
==================

# data_mem_ctrl

Parametrised data-memory controller for the ARM core's load/store path. It replaces the fixed word-only single-cycle data RAM and its separate byte-extraction logic with one block. The block adds configurable depth and wait states, a req/ready handshake, byte/halfword/word stores with lane preservation, sign- or zero-extended sub-word loads, and error reporting for misaligned or out-of-range accesses. It sits between the datapath's ALUResult/WriteData and the Result mux.

## Interface
Parameters:
- DEPTH_WORDS, 64: number of 32-bit words; legal range 1..65536.
- WAIT_STATES, 0: extra access cycles per transaction; legal range 0..15.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req  in  1  request strobe; sampled when busy=0.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- signed_ld  in  1  1 = sign-extend sub-word loads; ignored for words and stores.
- addr  in  32  byte address, little-endian.
- wdata  in  32  store data, right-aligned: byte uses [7:0], halfword uses [15:0].
- rdata  out  32  load result, registered; valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  completion status; valid while ready=1.
- busy  out  1  transaction in progress; requests are not accepted.

## Operation
- FSM states:
  - IDLE: busy=0, ready=0.
  - ACCESS: busy=1, wait counter active.
  - RESP: busy=0, ready=1.
- Accept: a request is accepted on a rising edge where state ∈ {IDLE, RESP} and req=1.
  - On accept, we, size, signed_ld, addr and wdata are latched and the counter is loaded with WAIT_STATES.
  - Next state is ACCESS.
- req is ignored while busy=1. Input changes after accept have no effect.
- ACCESS: the counter decrements each edge while nonzero. On the edge where the counter is 0:
  - the access is performed;
  - rdata and err are registered;
  - next state is RESP.
- RESP: lasts exactly one cycle.
  - With req=1, the next request is accepted (back-to-back).
  - Otherwise the state returns to IDLE.
- Error conditions, any one of which sets err=1:
  - size=11;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠00;
  - addr[31:2] ≥ DEPTH_WORDS.
- On error: no array write, rdata=0. The handshake timing is unchanged.
- Stores:
  - byte: writes wdata[7:0] into lane addr[1:0];
  - halfword: writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1};
  - word: writes all 4 lanes.
  - Lanes that are not written keep their value.
- Loads:
  - byte: the lane selected by addr[1:0], zero- or sign-extended from bit 7;
  - halfword: the selected half, zero- or sign-extended from bit 15;
  - word: the whole word.
  - A completed store returns rdata=0.
- Array contents are not initialised by reset. Simulation preload through $readmemh is permitted.

## Timing
- Reset values: state IDLE, rdata=0, ready=0, err=0, busy=0, counter=0.
- Latency: req=1 in cycle 0 (accepted at the end of cycle 0) gives ready=1 in cycle WAIT_STATES+2.
  - The array write commits at the end of cycle WAIT_STATES+1.
- Throughput: one transaction per WAIT_STATES+2 cycles using RESP-cycle acceptance.
- A load issued in the RESP cycle of a store to the same word returns the new data.
- busy=1 exactly during cycles 1..WAIT_STATES+1 of each transaction.
- Reset asserted mid-transaction (state ACCESS or RESP):
  - all outputs go to their reset values immediately;
  - an in-flight store that has not reached its commit edge is aborted, with the array unchanged;
  - a store that already committed stays committed.
- ready, err and rdata are driven from registers only; there are no combinational paths from req or addr to the outputs.

## Test plan
- Word store then load, WAIT_STATES=2, DEPTH_WORDS=64:
  - store addr=0x64, wdata=7, req in cycle 0 → busy in cycles 1–3, ready=1 and err=0 in cycle 4;
  - load of 0x64 → rdata=0x00000007.
- Byte and halfword stores, WAIT_STATES=0:
  - word 0x11223344 at 0x40;
  - STRB 0xAA at 0x42;
  - STRH 0xBEEF at 0x40;
  - load word 0x40 → 0x11AABEEF.
- Sub-word loads of 0x11AABEEF at 0x40:
  - byte at 0x41, unsigned → 0x000000BE;
  - byte at 0x41, signed → 0xFFFFFFBE;
  - half at 0x42, signed → 0x000011AA.
- Errors:
  - word load at 0x42 → err=1, rdata=0;
  - store to addr=0x100 with DEPTH_WORDS=64 → err=1, and a following load of word 0 is unchanged;
  - size=11 → err=1.
- Back-to-back: WAIT_STATES=0, req held high for 3 transactions → ready in cycles 2, 4 and 6; busy never high when ready is high.
- Reset mid-operation: WAIT_STATES=3, a store is accepted and reset is pulsed in cycle 2 → outputs return to their reset values immediately, and a later load of the target word shows the old value.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte/half/word load-store with lane preservation, sub-word extension, error flags.
// Latency: request accepted on edge 0 completes with a one-cycle ready pulse WAIT_STATES+2 cycles later.
// Backpressure: busy=1 while an access is in flight; req is only sampled in IDLE or in the RESP cycle.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        signed_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_we;
    logic [1:0]    r_size;
    logic          r_signed_ld;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_err;
    logic          r_busy;

    // Storage is deliberately left out of reset so it maps onto a plain RAM.
    logic [31:0]   r_mem [0:DEPTH_WORDS-1];

    logic          w_accept;
    logic          w_perform;
    logic          w_misalign;
    logic          w_oob;
    logic          w_err;
    logic          w_wr_en;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ld;
    logic [3:0]    w_be;
    logic [31:0]   w_wlane;

    assign w_accept  = req && ((r_state == S_IDLE) || (r_state == S_RESP));
    assign w_perform = (r_state == S_ACCESS) && (r_cnt == 4'd0);

    // Errors are judged on the latched request, so input changes after accept cannot affect them.
    assign w_misalign = (r_size == 2'b11)
                      | ((r_size == 2'b01) & r_addr[0])
                      | ((r_size == 2'b10) & (|r_addr[1:0]));
    assign w_oob      = ({2'b00, r_addr[31:2]} >= $unsigned(32'(DEPTH_WORDS)));
    assign w_err      = w_misalign | w_oob;

    assign w_idx   = r_addr[AW+1:2];
    assign w_rword = r_mem[w_idx];
    assign w_wr_en = w_perform & r_we & ~w_err;

    // Extract the addressed lane(s) of the read word and extend to 32 bits.
    always_comb begin
        w_byte = w_rword[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
        w_ld   = w_rword;
        case (r_size)
            2'b00:   w_ld = {{24{r_signed_ld & w_byte[7]}}, w_byte};
            2'b01:   w_ld = {{16{r_signed_ld & w_half[15]}}, w_half};
            default: w_ld = w_rword;
        endcase
    end

    // Replicate store data across lanes and pick the byte enables for the access size.
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = r_wdata;
        case (r_size)
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{r_wdata[15:0]}};
            end
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Byte-lane write on the commit edge; unselected lanes keep their contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM: latch request, count wait states, register the response for one RESP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_signed_ld <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (w_accept) begin
                        r_we        <= we;
                        r_size      <= size;
                        r_signed_ld <= signed_ld;
                        r_addr      <= addr;
                        r_wdata     <= wdata;
                        r_cnt       <= 4'(WAIT_STATES);
                        r_busy      <= 1'b1;
                        r_state     <= S_ACCESS;
                    end else begin
                        r_state     <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Stores and faulting accesses return zero data.
                        r_rdata <= (w_err | r_we) ? 32'd0 : w_ld;
                        r_err   <= w_err;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata = r_rdata;
    assign ready = r_ready;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule
